// File: rtl/baud_rate_generator_pkg.sv
// Shared types and constants for the UART baud-rate tick generator.
package baud_rate_generator_pkg;

  localparam int CD_W = 13;

  typedef logic [CD_W-1:0] baud_div_t;

  // A divisor of zero stops the generator.
  localparam baud_div_t CD_DISABLE = '0;

endpackage

// File: rtl/baud_rate_generator_if.sv
// Control and tick signals between the UART core and the baud-rate generator.
interface baud_rate_generator_if;
  import baud_rate_generator_pkg::*;

  logic      uart_mode_sel;
  logic      baud_div_16;
  baud_div_t cd;
  logic      baud_tick;

  modport master (output uart_mode_sel, output baud_div_16, output cd, input baud_tick);
  modport slave  (input uart_mode_sel, input baud_div_16, input cd, output baud_tick);

endinterface

// File: rtl/baud_rate_generator_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a rising-edge detector.
// The output pulse is one clock wide and is built only from flops in this clock domain.
module sync_edge_det #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [STG-1:0] sync;
  logic           sync_qq;

  // Shift the raw input through the synchronizer and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      sync_qq <= 1'b0;
    end else begin
      sync    <= {sync[STG-2:0], d};
      sync_qq <= sync[STG-1];
    end
  end

  assign pulse = sync[STG-1] & ~sync_qq;

endmodule

// File: rtl/baud_rate_generator.sv
// UART baud-rate tick generator: counts enables and emits one registered tick per cd enables.
// The enable is every clock (mode 0) or each synchronized rising edge of baud_div_16 (mode 1).
module baud_rate_generator
  import baud_rate_generator_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic                  uart_ref_clk,
  input  logic                  rst_n,
  baud_rate_generator_if.slave  bus
);

  logic      en_edge;
  logic      en;
  baud_div_t cd_m1;
  baud_div_t counter;
  logic      tick_q;

  sync_edge_det #(
    .STG (SYNC_STG)
  ) u_sync_edge_det (
    .clk   (uart_ref_clk),
    .rst_n (rst_n),
    .d     (bus.baud_div_16),
    .pulse (en_edge)
  );

  assign en    = bus.uart_mode_sel ? en_edge : 1'b1;
  assign cd_m1 = bus.cd - baud_div_t'(1);

  // Divider: a cd change applies at once; if the counter already sits at or past the new
  // terminal it wraps on the next enable rather than running round the full width.
  always_ff @(posedge uart_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      tick_q  <= 1'b0;
    end else if (bus.cd == CD_DISABLE) begin
      counter <= '0;
      tick_q  <= 1'b0;
    end else if (!en) begin
      tick_q  <= 1'b0;
    end else if (counter >= cd_m1) begin
      counter <= '0;
      tick_q  <= 1'b1;
    end else begin
      counter <= counter + baud_div_t'(1);
      tick_q  <= 1'b0;
    end
  end

  assign bus.baud_tick = tick_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator: reset, mode 0/1 tick spacing, cd changes,
// disable, cd=1 and a mid-count mode switch.
module tb_baud_rate_generator;
  import baud_rate_generator_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  baud_rate_generator_if bus();

  baud_rate_generator #(.SYNC_STG(2)) dut (
    .uart_ref_clk (clk),
    .rst_n        (rst_n),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic mode, input int div);
    rst_n             = 1'b0;
    bus.uart_mode_sel = mode;
    bus.cd            = baud_div_t'(div);
    bus.baud_div_16   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n             = 1'b1;
    bus.uart_mode_sel = 1'b0;
    bus.cd            = baud_div_t'(8);
    bus.baud_div_16   = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    n_checks++;
    if (bus.baud_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tick: got %b expected 0", bus.baud_tick);
    end
    n_checks++;
    if (dut.counter !== baud_div_t'(0)) begin
      n_fail++;
      $display("FAIL reset_counter: got %0d expected 0", dut.counter);
    end
  endtask

  task automatic test_mode0();
    apply_reset(1'b0, 8);
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== ((k % 8) == 0)) begin
        n_fail++;
        $display("FAIL mode0_cd8 edge %0d: got %b expected %b", k, bus.baud_tick, (k % 8) == 0);
      end
    end
  endtask

  // Continues from test_mode0: counter is 0 just after a tick.
  task automatic test_cd_change();
    for (int k = 1; k <= 3; k++) step();
    n_checks++;
    if (dut.counter !== baud_div_t'(3)) begin
      n_fail++;
      $display("FAIL cd_change_pre_counter: got %0d expected 3", dut.counter);
    end
    bus.cd = baud_div_t'(10);
    for (int k = 1; k <= 34; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== (k == 7 || k == 17 || k == 27)) begin
        n_fail++;
        $display("FAIL cd_8_to_10 edge %0d: got %b expected %b", k, bus.baud_tick,
                 (k == 7 || k == 17 || k == 27));
      end
    end
    n_checks++;
    if (dut.counter !== baud_div_t'(7)) begin
      n_fail++;
      $display("FAIL cd_change_mid_counter: got %0d expected 7", dut.counter);
    end
    bus.cd = baud_div_t'(5);
    for (int k = 1; k <= 16; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== ((k % 5) == 1)) begin
        n_fail++;
        $display("FAIL cd_10_to_5 edge %0d: got %b expected %b", k, bus.baud_tick, (k % 5) == 1);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0, 8);
    for (int k = 1; k <= 8; k++) step();
    n_checks++;
    if (bus.baud_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_tick: got %b expected 1", bus.baud_tick);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.baud_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_tick_clear: got %b expected 0", bus.baud_tick);
    end
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) step();
    n_checks++;
    if (dut.counter !== baud_div_t'(3)) begin
      n_fail++;
      $display("FAIL async_pre_counter: got %0d expected 3", dut.counter);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.counter !== baud_div_t'(0)) begin
      n_fail++;
      $display("FAIL async_counter_clear: got %0d expected 0", dut.counter);
    end
  endtask

  // baud_div_16 period is 8 clocks; it rises just after edge k when k%8==4.
  task automatic test_mode1();
    apply_reset(1'b1, 5);
    for (int k = 1; k <= 80; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== (k == 39 || k == 79)) begin
        n_fail++;
        $display("FAIL mode1_cd5 edge %0d: got %b expected %b", k, bus.baud_tick,
                 (k == 39 || k == 79));
      end
      bus.baud_div_16 = ((k % 8) >= 4);
    end
  endtask

  task automatic test_disable();
    apply_reset(1'b0, 0);
    for (int k = 1; k <= 100; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL cd0_mode0 edge %0d: got %b expected 0", k, bus.baud_tick);
      end
    end
    bus.uart_mode_sel = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL cd0_mode1 edge %0d: got %b expected 0", k, bus.baud_tick);
      end
      bus.baud_div_16 = ((k % 8) >= 4);
    end
    n_checks++;
    if (dut.counter !== baud_div_t'(0)) begin
      n_fail++;
      $display("FAIL cd0_counter: got %0d expected 0", dut.counter);
    end
    bus.uart_mode_sel = 1'b0;
    bus.baud_div_16   = 1'b0;
    bus.cd            = baud_div_t'(1);
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (bus.baud_tick !== 1'b1) begin
        n_fail++;
        $display("FAIL cd1_continuous edge %0d: got %b expected 1", k, bus.baud_tick);
      end
    end
  endtask

  task automatic test_mode_switch();
    apply_reset(1'b0, 8);
    for (int k = 1; k <= 3; k++) step();
    n_checks++;
    if (dut.counter !== baud_div_t'(3)) begin
      n_fail++;
      $display("FAIL switch_pre_counter: got %0d expected 3", dut.counter);
    end
    bus.uart_mode_sel = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (dut.counter !== baud_div_t'(3)) begin
          n_fail++;
          $display("FAIL switch_counter_kept: got %0d expected 3", dut.counter);
        end
      end
      n_checks++;
      if (bus.baud_tick !== (k == 39)) begin
        n_fail++;
        $display("FAIL switch_tick edge %0d: got %b expected %b", k, bus.baud_tick, k == 39);
      end
      bus.baud_div_16 = ((k % 8) >= 4);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mode0();
    test_cd_change();
    test_async_reset();
    test_mode1();
    test_disable();
    test_mode_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
